// File: rtl/fft_peak_scan_if.sv
// fft_peak_scan_if: bin read bus to the FFT result register file plus the magnitude stream.
interface fft_peak_scan_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   s_addr;
    logic                    s_re;
    logic [2*DATA_WIDTH-1:0] s_data;
    logic [DATA_WIDTH:0]     mag_data;
    logic [ADDR_WIDTH-1:0]   mag_bin;
    logic                    mag_valid;
    logic                    mag_ready;
    modport master (
        output s_addr, s_re, mag_data, mag_bin, mag_valid,
        input  s_data, mag_ready
    );
    modport slave (
        input  s_addr, s_re, mag_data, mag_bin, mag_valid,
        output s_data, mag_ready
    );
endinterface

// File: rtl/fft_peak_scan.sv
// fft_peak_scan: reads DEPTH FFT bins, streams |re|+|im| per bin and tracks the first largest one.
module fft_peak_scan #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    fft_peak_scan_if.master       bus,
    output logic [DATA_WIDTH:0]   peak_mag,
    output logic [ADDR_WIDTH-1:0] peak_bin,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, RD, CAP, XFER, DONE} state_t;
    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [DATA_WIDTH:0]     mag_q;
    logic [ADDR_WIDTH-1:0]   bin_q;
    logic signed [DATA_WIDTH-1:0] re, im;
    logic [DATA_WIDTH-1:0]   abs_re, abs_im;
    logic [DATA_WIDTH:0]     mag;
    logic                    last;
    // Negating the most negative value wraps to the same bit pattern, which read unsigned is exactly 2^(DATA_WIDTH-1).
    always_comb begin
        re     = bus.s_data[2*DATA_WIDTH-1:DATA_WIDTH];
        im     = bus.s_data[DATA_WIDTH-1:0];
        abs_re = re[DATA_WIDTH-1] ? DATA_WIDTH'(-re) : DATA_WIDTH'(re);
        abs_im = im[DATA_WIDTH-1] ? DATA_WIDTH'(-im) : DATA_WIDTH'(im);
        mag    = {1'b0, abs_re} + {1'b0, abs_im};
        last   = idx == ADDR_WIDTH'(DEPTH - 1);
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? RD : IDLE;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = XFER;
            XFER:    state_nxt = bus.mag_ready ? (last ? DONE : RD) : XFER;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            mag_q    <= '0;
            bin_q    <= '0;
            peak_mag <= '0;
            peak_bin <= '0;
        end else begin
            if (state == IDLE && start) begin
                idx      <= '0;
                peak_mag <= '0;
                peak_bin <= '0;
            end
            if (state == CAP) begin
                mag_q <= mag;
                bin_q <= idx;
                if (mag > peak_mag) begin
                    peak_mag <= mag;
                    peak_bin <= idx;
                end
            end
            if (state == XFER && bus.mag_ready && !last) idx <= idx + 1'b1;
        end
    end
    assign bus.s_re      = state == RD;
    assign bus.s_addr    = idx;
    assign bus.mag_valid = state == XFER;
    assign bus.mag_data  = mag_q;
    assign bus.mag_bin   = bin_q;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
endmodule

// File: tb/tb_fft_peak_scan.sv
// tb_fft_peak_scan: table vectors, directed corner scans and random scans against a bin-list reference model.
module tb_fft_peak_scan;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int N  = 32;
    typedef struct {int re; int im; int mag;} vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [DW:0]     peak_mag;
    logic [AW-1:0]   peak_bin;
    logic            busy, done;
    logic [2*DW-1:0] mem [N];
    int n_cmp = 0, n_bad = 0;
    int got_bin[$], got_mag[$];
    int rd_first, done_cyc, done_cnt, low_cnt, bad_sre, bad_hold, bad_addr, bad_busy, rd_cnt;
    fft_peak_scan_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    fft_peak_scan #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(N)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .peak_mag(peak_mag), .peak_bin(peak_bin), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    // Result register file: one-cycle read latency, junk when not read so early sampling shows up.
    always_ff @(posedge clk) bus.s_data <= bus.s_re ? mem[bus.s_addr] : 32'hDEAD_BEEF;
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    function automatic int mag_of(input logic [2*DW-1:0] w);
        int re = $signed(w[2*DW-1:DW]);
        int im = $signed(w[DW-1:0]);
        return (re < 0 ? -re : re) + (im < 0 ? -im : im);
    endfunction
    function automatic logic [2*DW-1:0] pack(input int re, input int im);
        return {DW'(re), DW'(im)};
    endfunction
    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction
    task automatic fill_zero();
        for (int i = 0; i < N; i++) mem[i] = '0;
    endtask
    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < N; i++) mem[i] = pack(rnd(lo, hi), rnd(lo, hi));
    endtask
    task automatic run_scan(input int stall_bin, input int stall_len, input bit rand_ready, input int start_at);
        int  stalled = 0, it = 0;
        bit  hold = 1'b0, restarted = 1'b0;
        logic [DW:0]   pd = '0;
        logic [AW-1:0] pb = '0;
        got_bin.delete();
        got_mag.delete();
        rd_first = -1; done_cyc = -1; done_cnt = 0; low_cnt = 0;
        bad_sre = 0; bad_hold = 0; bad_addr = 0; bad_busy = 0; rd_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        bus.mag_ready = 1'b1;
        while ((done_cyc < 0 || it < done_cyc + 4) && it < 1000) begin
            @(negedge clk);
            start = 1'b0;
            if (!restarted && start_at >= 0 && bus.mag_valid && int'(bus.mag_bin) == start_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (bus.mag_valid && int'(bus.mag_bin) == stall_bin && stalled < stall_len) begin
                bus.mag_ready = 1'b0;
                stalled++;
            end else bus.mag_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.s_re) begin
                if (rd_first < 0) rd_first = it;
                if (bus.s_addr != AW'(rd_cnt)) bad_addr++;
                rd_cnt++;
            end
            if (bus.mag_valid && bus.s_re) bad_sre++;
            if (hold && (!bus.mag_valid || bus.mag_data != pd || bus.mag_bin != pb)) bad_hold++;
            hold = bus.mag_valid && !bus.mag_ready;
            pd = bus.mag_data;
            pb = bus.mag_bin;
            if (bus.mag_valid && !bus.mag_ready) low_cnt++;
            if (bus.mag_valid && bus.mag_ready) begin
                got_bin.push_back(int'(bus.mag_bin));
                got_mag.push_back(int'(bus.mag_data));
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = it;
            end
            if (!busy && done_cyc < 0) bad_busy++;
            it++;
        end
        start = 1'b0;
        bus.mag_ready = 1'b1;
    endtask
    // Reference: every bin exactly once in order, magnitude |re|+|im|, peak is the first bin holding the maximum.
    task automatic check_scan(input string name);
        int exp_pk = -1, exp_pb = 0, m, bad_bins = 0;
        for (int i = 0; i < N; i++) begin
            m = mag_of(mem[i]);
            if (m > exp_pk) begin
                exp_pk = m;
                exp_pb = i;
            end
            if (i < got_bin.size() && (got_bin[i] != i || got_mag[i] != m)) bad_bins++;
        end
        check({name, "_bin_count"}, got_bin.size(), N);
        check({name, "_bin_values"}, bad_bins, 0);
        check({name, "_peak_mag"}, peak_mag, exp_pk);
        check({name, "_peak_bin"}, peak_bin, exp_pb);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_latency"}, done_cyc - rd_first, 3 * N + low_cnt);
        check({name, "_protocol_errs"}, bad_sre + bad_hold + bad_addr + bad_busy, 0);
        check({name, "_busy_after"}, busy, 0);
    endtask
    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_s_re"}, bus.s_re, 0);
        check({name, "_s_addr"}, bus.s_addr, 0);
        check({name, "_mag_valid"}, bus.mag_valid, 0);
        check({name, "_mag_data"}, bus.mag_data, 0);
        check({name, "_mag_bin"}, bus.mag_bin, 0);
        check({name, "_peak_mag"}, peak_mag, 0);
        check({name, "_peak_bin"}, peak_bin, 0);
    endtask
    initial begin
        vec_t tbl[8];
        int   dn;
        bit   found;
        tbl = '{'{300, -400, 700}, '{-32768, -32768, 65536}, '{32767, 32767, 65534}, '{0, 0, 0},
                '{-1, 1, 2}, '{-32768, 32767, 65535}, '{1000, 0, 1000}, '{-5, -7, 12}};
        bus.mag_ready = 1'b1;
        fill_zero();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);
        fill_zero();
        mem[5] = pack(300, -400);
        run_scan(-1, 0, 1'b0, -1);
        check_scan("basic");
        check("basic_bin5_mag", got_mag[5], 700);
        check("basic_peak_mag", peak_mag, 700);
        check("basic_peak_bin", peak_bin, 5);
        check("basic_latency", done_cyc - rd_first, 96);
        check("basic_peak_hold", peak_mag, 700);
        fill_zero();
        mem[0] = pack(-32768, -32768);
        run_scan(-1, 0, 1'b0, -1);
        check_scan("extreme");
        check("extreme_bin0_mag", got_mag[0], 65536);
        check("extreme_peak_bin", peak_bin, 0);
        fill_zero();
        for (int i = 0; i < 8; i++) mem[i] = pack(tbl[i].re, tbl[i].im);
        run_scan(-1, 0, 1'b0, -1);
        for (int i = 0; i < 8; i++) check($sformatf("table_mag%0d", i), got_mag[i], tbl[i].mag);
        check("table_peak_mag", peak_mag, 65536);
        check("table_peak_bin", peak_bin, 1);
        fill_rand(-400, 400);
        mem[3]  = pack(600, -400);
        mem[20] = pack(-1000, 0);
        run_scan(-1, 0, 1'b0, -1);
        check_scan("tie");
        check("tie_peak_bin", peak_bin, 3);
        check("tie_peak_mag", peak_mag, 1000);
        fill_rand(-32768, 32767);
        run_scan(7, 4, 1'b0, -1);
        check_scan("stall");
        check("stall_latency", done_cyc - rd_first, 100);
        check("stall_hold_errs", bad_hold, 0);
        fill_rand(-32768, 32767);
        run_scan(-1, 0, 1'b0, 10);
        check_scan("restart_ignored");
        for (int k = 0; k < 3; k++) begin
            fill_rand(-32768, 32767);
            run_scan(-1, 0, 1'b1, -1);
            check_scan($sformatf("rand%0d", k));
        end
        fill_rand(-32768, 32767);
        found = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            bus.mag_ready = !(bus.mag_valid && bus.mag_bin == AW'(12));
            if (!bus.mag_ready) begin
                found = 1'b1;
                rst = 1'b0;
                #1;
                check_reset_outputs("mid_rst");
            end
        end
        check("mid_rst_reached_bin12", found, 1);
        bus.mag_ready = 1'b1;
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            dn += int'(done);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            dn += int'(done);
        end
        check("mid_rst_no_done", dn, 0);
        check("mid_rst_stays_idle", busy, 0);
        run_scan(-1, 0, 1'b0, -1);
        check_scan("after_rst");
        check("after_rst_first_bin", got_bin[0], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_peak_scan.md
FFT_PEAK_SCAN -- requirements
Module: fft_peak_scan

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, giving the bin address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, giving the width of each real/imag component.
REQ-003 SHALL have parameter DEPTH, default 32, giving the number of FFT bins scanned.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-007 SHALL have port s_addr, output, ADDR_WIDTH bits: bin read address to the slave result register file.
REQ-008 SHALL have port s_re, output, 1 bit: read enable to the slave result register file.
REQ-009 SHALL have port s_data, input, 2*DATA_WIDTH bits: bin value, real in [2*DATA_WIDTH-1:DATA_WIDTH] and imag in [DATA_WIDTH-1:0], signed two's complement, valid the cycle after s_re.
REQ-010 SHALL have port mag_data, output, DATA_WIDTH+1 bits: unsigned magnitude of the current bin.
REQ-011 SHALL have port mag_bin, output, ADDR_WIDTH bits: bin index of mag_data.
REQ-012 SHALL have port mag_valid, output, 1 bit: mag_data/mag_bin valid.
REQ-013 SHALL have port mag_ready, input, 1 bit: downstream accepts when mag_valid and mag_ready are both high.
REQ-014 SHALL have port peak_mag, output, DATA_WIDTH+1 bits: largest magnitude seen in the scan.
REQ-015 SHALL have port peak_bin, output, ADDR_WIDTH bits: bin of peak_mag.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at scan end.

Function
REQ-018 SHALL implement the FSM IDLE, RD, CAP, XFER, DONE with a bin counter idx.
REQ-019 SHALL move IDLE->RD when start=1, clearing idx, peak_mag and peak_bin to 0 on that edge.
REQ-020 SHALL in RD drive s_re=1 and s_addr=idx for exactly one cycle, then go to CAP; s_re SHALL be 0 in every other state.
REQ-021 SHALL in CAP register mag_data=|re|+|im|, with the abs of the most negative value (-2^(DATA_WIDTH-1)) giving 2^(DATA_WIDTH-1) and no overflow, load mag_bin=idx, and then go to XFER.
REQ-022 SHALL in CAP replace peak_mag/peak_bin only when the new magnitude is strictly greater, so ties keep the lowest bin.
REQ-023 SHALL in XFER hold mag_valid=1 with mag_data/mag_bin stable until mag_ready=1; on acceptance go to DONE if idx=DEPTH-1, otherwise increment idx and go to RD.
REQ-024 SHALL take 3 cycles per bin with mag_ready held high, giving 3*DEPTH cycles from the first RD to DONE.
REQ-025 SHALL in DONE assert done=1 for one cycle and return to IDLE; peak_mag/peak_bin SHALL hold until the next start.
REQ-026 SHALL ignore start while busy=1, with no restart and no effect on idx.
REQ-027 SHALL keep mag_valid low in all states other than XFER.

Reset
REQ-028 SHALL, while rst=0, immediately force state=IDLE, idx=0, s_addr=0, s_re=0, mag_valid=0, mag_data=0, mag_bin=0, peak_mag=0, peak_bin=0, busy=0 and done=0.
REQ-029 SHALL, when reset is asserted mid-scan, abandon the scan with no done pulse and require a new start after rst returns high.

Verification
REQ-030 SHALL verify the basic scan: all bins 0 except bin 5 = (re 300, im -400), mag_ready=1 -> bin 5 mag_data=700, peak_bin=5, peak_mag=700, done exactly 96 cycles after the first RD.
REQ-031 SHALL verify the extreme value: bin 0 = (-32768, -32768) -> mag_data=65536 (17'h10000), peak_bin=0.
REQ-032 SHALL verify tie-breaking: bins 3 and 20 both magnitude 1000, all others lower -> peak_bin=3.
REQ-033 SHALL verify backpressure: mag_ready low for 4 cycles in XFER of bin 7 -> mag_data/mag_bin stable, s_re=0, no bin skipped or repeated, total scan lengthened by 4 cycles.
REQ-034 SHALL verify start during a scan: start pulsed at bin 10 -> ignored, bins 0..31 each delivered once, single done pulse.
REQ-035 SHALL verify reset mid-scan: rst=0 during XFER of bin 12 -> all outputs at reset values that cycle, no done pulse; a new start then scans from bin 0.
